aes_cipher_core: RTL

//  Iterative AES-128 encryption datapath, directly downstream of key_expand.
//  - Loads a 128-bit plaintext as four 32-bit words.
//  - Fetches round keys one word per cycle through key_expand's indexed read

---
 rtl/aes_cipher_core_if.sv | 23 ++
 rtl/aes_cipher_core.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core_if.sv
// rtl/aes_cipher_core_if.sv - plaintext/round-key/ciphertext port bundle for aes_cipher_core
interface aes_cipher_core_if;
    logic        start;
    logic [31:0] pt_word;
    logic        key_ready;
    logic [31:0] rk_word;
    logic [3:0]  rk_num;
    logic [1:0]  rk_index;
    logic [31:0] ct_word;
    logic        ct_valid;
    logic        busy;
    logic        done;

    modport slave (
        input  start, pt_word, key_ready, rk_word,
        output rk_num, rk_index, ct_word, ct_valid, busy, done
    );

    modport master (
        output start, pt_word, key_ready, rk_word,
        input  rk_num, rk_index, ct_word, ct_valid, busy, done
    );
endinterface

// File: rtl/aes_cipher_core.sv
// rtl/aes_cipher_core.sv - iterative column-serial AES-128 encryption core
module aes_cipher_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               reset,
    aes_cipher_core_if.slave   io
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_KEY, S_ARK0, S_ROUND, S_OUT
    } state_t;

    // Forward S-box; byte x lives at bits {~x, 3'b111} -: 8.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] b);
        logic [7:0] a0, a1, a2, a3;
        a0 = b[31:24];
        a1 = b[23:16];
        a2 = b[15:8];
        a3 = b[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0][31:0] st_q, st_d;
    logic [2:0][31:0] nx_q, nx_d;
    logic [31:0]      sub_w, col_out;
    logic [1:0]       c1, c2, c3;

    // One output column of a round: SubBytes+ShiftRows, MixColumns (skipped in last round), AddRoundKey.
    always_comb begin
        c1      = col_q + 2'd1;
        c2      = col_q + 2'd2;
        c3      = col_q + 2'd3;
        sub_w   = {sbox(st_q[col_q][31:24]), sbox(st_q[c1][23:16]),
                   sbox(st_q[c2][15:8]),     sbox(st_q[c3][7:0])};
        col_out = ((rnd_q == 4'(NUM_ROUNDS)) ? sub_w : mix_col(sub_w)) ^ io.rk_word;
    end

    // Next-state and datapath updates; key-consuming states freeze while key_ready is low.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        nx_d    = nx_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    state_d = S_LOAD;
                    col_d   = 2'd0;
                    rnd_d   = 4'd0;
                end
            end
            S_LOAD: begin
                st_d[col_q] = io.pt_word;
                col_d       = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = io.key_ready ? S_ARK0 : S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                if (io.key_ready) begin
                    state_d = S_ARK0;
                end
            end
            S_ARK0: begin
                if (io.key_ready) begin
                    st_d[col_q] = st_q[col_q] ^ io.rk_word;
                    col_d       = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = S_ROUND;
                        rnd_d   = 4'd1;
                    end
                end
            end
            S_ROUND: begin
                if (io.key_ready) begin
                    col_d = col_q + 2'd1;
                    if (col_q != 2'd3) begin
                        nx_d[col_q] = col_out;
                    end else begin
                        // Columns 0..2 were buffered so ShiftRows kept reading the old state.
                        st_d = {col_out, nx_q[2], nx_q[1], nx_q[0]};
                        if (rnd_q == 4'(NUM_ROUNDS)) begin
                            state_d = S_OUT;
                            rnd_d   = 4'd0;
                        end else begin
                            rnd_d = rnd_q + 4'd1;
                        end
                    end
                end
            end
            S_OUT: begin
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= 2'd0;
            rnd_q   <= 4'd0;
            st_q    <= '0;
            nx_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            nx_q    <= nx_d;
        end
    end

    assign io.rk_num   = rnd_q;
    assign io.rk_index = col_q;
    assign io.ct_valid = (state_q == S_OUT);
    assign io.ct_word  = (state_q == S_OUT) ? st_q[col_q] : 32'h0;
    assign io.done     = (state_q == S_OUT) && (col_q == 2'd3);
    assign io.busy     = (state_q != S_IDLE);

endmodule
